// File: rtl/structural_gate_pkg.sv
// Shared definitions for the truth-table sweeper and its settle timer.
package structural_gate_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int         DEF_N_IN     = 3;
    localparam logic [7:0] DEF_EXPECTED = 8'h9A;

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter with zero flag; paces how long each vector is held.
module sweep_timer #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a combinational DUT, captures its response
// after a settle time and grades the captured table against EXPECTED.
module truth_table_sweeper
    import structural_gate_pkg::*;
#(
    parameter int                   N_IN     = DEF_N_IN,
    parameter int                   SETTLE   = 1,
    parameter logic [2**N_IN-1:0]   EXPECTED = DEF_EXPECTED
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    output logic [N_IN-1:0]     ABC,
    input  logic                F_IN,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [2**N_IN-1:0]  CAPTURED,
    output logic [N_IN:0]       ERR_COUNT,
    output logic [N_IN-1:0]     FIRST_ERR
);

    localparam int             CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(SETTLE - 1);

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("truth_table_sweeper: SETTLE must be >= 1");
        end
    endgenerate

    state_t               r_state, w_state_nxt;
    logic [N_IN-1:0]      r_abc;
    logic                 r_done;
    logic                 r_pass;
    logic [2**N_IN-1:0]   r_captured;
    logic [N_IN:0]        r_err;
    logic [N_IN-1:0]      r_first;
    logic                 r_first_seen;

    logic w_zero, w_accept, w_sample, w_last, w_mis, w_load, w_dec;

    assign w_accept = (r_state == ST_IDLE) && START;
    assign w_sample = (r_state == ST_RUN) && w_zero;
    assign w_last   = &r_abc;
    assign w_mis    = (F_IN != EXPECTED[r_abc]);
    assign w_load   = w_accept || (w_sample && !w_last);
    assign w_dec    = (r_state == ST_RUN) && !w_zero;

    sweep_timer #(.W(CW)) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_load),
        .i_load_val (RELOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state: START accepted only when idle; leave RUN after the last sample.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (START)             w_state_nxt = ST_RUN;
            ST_RUN:  if (w_sample && w_last) w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    // Vector stepping, capture and grading; results clear on an accepted START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_abc        <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_captured   <= '0;
            r_err        <= '0;
            r_first      <= '0;
            r_first_seen <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_abc        <= '0;
                r_pass       <= 1'b0;
                r_captured   <= '0;
                r_err        <= '0;
                r_first      <= '0;
                r_first_seen <= 1'b0;
            end else if (w_sample) begin
                r_captured[r_abc] <= F_IN;
                if (w_mis) begin
                    r_err <= r_err + (N_IN+1)'(1);
                    if (!r_first_seen) begin
                        r_first      <= r_abc;
                        r_first_seen <= 1'b1;
                    end
                end
                if (w_last) begin
                    r_abc  <= '0;
                    r_done <= 1'b1;
                    r_pass <= (r_err == '0) && !w_mis;
                end else begin
                    r_abc <= r_abc + N_IN'(1);
                end
            end
        end
    end

    assign ABC       = r_abc;
    assign BUSY      = (r_state == ST_RUN);
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign CAPTURED  = r_captured;
    assign ERR_COUNT = r_err;
    assign FIRST_ERR = r_first;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) whose
// F_IN is looked up from a per-instance response table chosen by the bench.
module tb_truth_table_sweeper;

    localparam logic [7:0] EXP = 8'h9A;

    logic       CLK;
    logic       RST;
    logic       start    [2];
    logic       fin      [2];
    logic [2:0] abc      [2];
    logic       busy     [2];
    logic       done     [2];
    logic       pass     [2];
    logic [7:0] captured [2];
    logic [3:0] errc     [2];
    logic [2:0] ferr     [2];
    logic [7:0] tbl      [2];

    int n_cmp = 0;
    int n_err = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DUT response: whatever table the bench selected, indexed by the vector.
    assign fin[0] = tbl[0][abc[0]];
    assign fin[1] = tbl[1][abc[1]];

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(EXP)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(start[0]), .ABC(abc[0]), .F_IN(fin[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .CAPTURED(captured[0]),
        .ERR_COUNT(errc[0]), .FIRST_ERR(ferr[0])
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECTED(EXP)) u_dut3 (
        .CLK(CLK), .RST(RST), .START(start[1]), .ABC(abc[1]), .F_IN(fin[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .CAPTURED(captured[1]),
        .ERR_COUNT(errc[1]), .FIRST_ERR(ferr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Full sweep on instance i with response table t. pre: START already set so
    // the next edge is E0. poke: pulse START at cycles 2 and 5 (must be ignored).
    // chain: raise START in the DONE cycle to launch a back-to-back sweep.
    task automatic sweep(input int i, input int settle, input logic [7:0] t,
                         input bit pre, input bit poke, input bit chain);
        logic [7:0] diff;
        int         nerr;
        int         first;
        diff  = t ^ EXP;
        nerr  = $countones(diff);
        first = 0;
        for (int k = 7; k >= 0; k--) if (diff[k]) first = k;
        tbl[i] = t;
        if (!pre) begin
            @(negedge CLK);
            start[i] = 1'b1;
        end
        @(posedge CLK); #1;
        start[i] = 1'b0;
        chk("e0_busy",  32'(busy[i]),     32'(1));
        chk("e0_abc",   32'(abc[i]),      32'(0));
        chk("e0_done",  32'(done[i]),     32'(0));
        chk("e0_cap",   32'(captured[i]), 32'(0));
        chk("e0_err",   32'(errc[i]),     32'(0));
        chk("e0_first", 32'(ferr[i]),     32'(0));
        chk("e0_pass",  32'(pass[i]),     32'(0));
        for (int c = 1; c <= 8 * settle; c++) begin
            @(posedge CLK); #1;
            if (c < 8 * settle) begin
                chk("run_abc",  32'(abc[i]),  32'(c / settle));
                chk("run_busy", 32'(busy[i]), 32'(1));
                chk("run_done", 32'(done[i]), 32'(0));
                start[i] = (poke && (c == 1 || c == 4)) ? 1'b1 : 1'b0;
            end else begin
                chk("end_done",  32'(done[i]),     32'(1));
                chk("end_busy",  32'(busy[i]),     32'(0));
                chk("end_abc",   32'(abc[i]),      32'(0));
                chk("end_cap",   32'(captured[i]), 32'(t));
                chk("end_err",   32'(errc[i]),     32'(nerr));
                chk("end_first", 32'(ferr[i]),     32'(first));
                chk("end_pass",  32'(pass[i]),     32'(diff == 8'h00));
                if (chain) begin
                    start[i] = 1'b1;
                end else begin
                    @(posedge CLK); #1;
                    chk("post_done", 32'(done[i]), 32'(0));
                    chk("post_pass", 32'(pass[i]), 32'(diff == 8'h00));
                    chk("post_cap",  32'(captured[i]), 32'(t));
                end
            end
        end
    endtask

    initial begin
        RST      = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        tbl[0]   = EXP;
        tbl[1]   = EXP;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_abc",   32'(abc[i]),      32'(0));
            chk("rst_busy",  32'(busy[i]),     32'(0));
            chk("rst_done",  32'(done[i]),     32'(0));
            chk("rst_pass",  32'(pass[i]),     32'(0));
            chk("rst_cap",   32'(captured[i]), 32'(0));
            chk("rst_err",   32'(errc[i]),     32'(0));
            chk("rst_first", 32'(ferr[i]),     32'(0));
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // SETTLE=1: correct gate, then tied-0, then inverse, chained back to back.
        sweep(0, 1, EXP,   1'b0, 1'b0, 1'b1);
        sweep(0, 1, 8'h00, 1'b1, 1'b0, 1'b1);
        sweep(0, 1, 8'h65, 1'b1, 1'b0, 1'b0);
        // START pulses mid-sweep are ignored.
        sweep(0, 1, EXP,   1'b0, 1'b1, 1'b0);
        // Random response tables.
        for (int r = 0; r < 8; r++)
            sweep(0, 1, 8'($urandom_range(0, 255)), 1'b0, (r % 2) == 1, 1'b0);

        // SETTLE=3.
        sweep(1, 3, EXP, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++)
            sweep(1, 3, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while ABC=4.
        tbl[0] = EXP;
        @(negedge CLK);
        start[0] = 1'b1;
        @(posedge CLK); #1;
        start[0] = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("pre_rst_abc", 32'(abc[0]), 32'(4));
        #2;
        RST = 1'b1;
        #1;
        chk("arst_abc",   32'(abc[0]),      32'(0));
        chk("arst_busy",  32'(busy[0]),     32'(0));
        chk("arst_done",  32'(done[0]),     32'(0));
        chk("arst_pass",  32'(pass[0]),     32'(0));
        chk("arst_cap",   32'(captured[0]), 32'(0));
        chk("arst_err",   32'(errc[0]),     32'(0));
        chk("arst_first", 32'(ferr[0]),     32'(0));
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            chk("arst_hold_done", 32'(done[0]), 32'(0));
            chk("arst_hold_busy", 32'(busy[0]), 32'(0));
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rel_done", 32'(done[0]), 32'(0));
        chk("rel_busy", 32'(busy[0]), 32'(0));
        sweep(0, 1, EXP, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus/response engine for small combinational gate blocks. On a START request it drives every N_IN-bit input vector to a device under test in ascending order. After a programmable settle time it samples the DUT's single output for each vector, builds the captured truth table, and compares it against an expected table. It sits beside a structural gate block in self-checking benches and on-chip BIST wrappers.

## Interface
- N_IN, 3, number of DUT inputs; table depth is 2**N_IN
- SETTLE, 1, clock cycles each vector is held before F_IN is sampled; must be >= 1 (0 is an elaboration error)
- EXPECTED, 8'h9A, expected truth table, width 2**N_IN; bit k = expected F for input vector k
- CLK  input  1  sole clock, rising-edge
- RST  input  1  asynchronous, active-high reset
- START  input  1  sweep request, sampled on rising CLK
- ABC  output  N_IN  vector driven to DUT, MSB = first DUT input
- F_IN  input  1  DUT response, same clock domain, no synchronizer
- BUSY  output  1  high while sweeping
- DONE  output  1  one-cycle pulse when a sweep completes
- PASS  output  1  CAPTURED == EXPECTED, valid from DONE until next accepted START
- CAPTURED  output  2**N_IN  sampled truth table
- ERR_COUNT  output  N_IN+1  number of mismatching vectors
- FIRST_ERR  output  N_IN  lowest mismatching vector index; 0 when PASS=1

## Operation
- The block has one clock, CLK. RST is asynchronous and active-high.
- States: IDLE, RUN.
- IDLE: START=1 is accepted. On that edge, state goes to RUN, BUSY=1, ABC=0, and the settle counter loads SETTLE-1. CAPTURED, ERR_COUNT, FIRST_ERR, PASS and the internal first-error flag all clear.
- RUN, settle counter != 0: decrement it and hold ABC.
- RUN, settle counter == 0: sample F_IN into CAPTURED[ABC].
  - If F_IN != EXPECTED[ABC], ERR_COUNT increments. FIRST_ERR takes ABC if this is the first mismatch.
  - If ABC != all-ones: ABC increments and the counter reloads SETTLE-1.
  - If ABC == all-ones: the state goes to IDLE. BUSY=0, DONE=1 for one cycle, and ABC returns to 0. PASS is set if the final error count, including this sample, is 0.
- START while BUSY is ignored and is not queued.
- START during the DONE cycle is legal, because the state is already IDLE. The new sweep begins and the previous results clear on that edge.
- ERR_COUNT saturates naturally at 2**N_IN; its width guarantees no wrap.
- Reset mid-sweep aborts immediately. No DONE is produced and all results are lost.

## Timing
- Reset values: ABC=0, BUSY=0, DONE=0, PASS=0, CAPTURED=0, ERR_COUNT=0, FIRST_ERR=0, state IDLE, counter 0.
- START accepted at edge E0.
  - Vector k is driven on ABC from E0+k*SETTLE.
  - Vector k is sampled at edge E0+(k+1)*SETTLE.
- DONE is high for the cycle following edge E0+2**N_IN*SETTLE. BUSY falls on that same edge.
- The DUT path from ABC through the DUT to F_IN must settle within SETTLE cycles minus setup.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package structural_gate_pkg holds:
  - state codes for IDLE and RUN;
  - the default EXPECTED constant 8'h9A;
  - the default N_IN.
- One sub-module, sweep_timer: a loadable down-counter with a zero flag that implements the settle counter. Everything else lives in truth_table_sweeper.

## Test plan
- Structural gate DUT (F=1 for vectors 1,3,4,7), SETTLE=1, START pulse. Required response:
  - DONE 8 cycles after the START edge;
  - CAPTURED=8'h9A, PASS=1, ERR_COUNT=0, FIRST_ERR=0;
  - ABC steps 0..7, one cycle each.
- F_IN tied 0. Required response: CAPTURED=8'h00, ERR_COUNT=4, FIRST_ERR=1, PASS=0.
- F_IN = inverse of the correct gate. Required response: CAPTURED=8'h65, ERR_COUNT=8, FIRST_ERR=0, PASS=0.
- SETTLE=3 with the correct DUT. Required response: each ABC value held 3 cycles, DONE 24 cycles after START, PASS=1.
- START pulsed at cycles 2 and 5 of a sweep. Required response: both ignored, a single DONE at cycle 8. START asserted in the DONE cycle starts a new sweep with results cleared on that edge.
- RST asserted asynchronously while ABC=4. Required response:
  - all outputs 0 immediately, with no DONE;
  - after release, a START runs a full 8-vector sweep with PASS=1.
